// File: rtl/lif_param_loader.sv
// lif_param_loader
// Serial configuration transmitter for the LIF neuron configuration receiver.
// A parallel parameter frame is latched on start and shifted out MSB first on
// serial_data while load_mode is high, each bit held CLK_DIV cycles. The block
// then waits up to TIMEOUT cycles for params_ready and reports the outcome.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   start        in   request a transfer (sampled only when idle)
//   abort        in   cancel an in-progress transfer
//   frame        in   FRAME_BITS parameter frame, latched on accepted start
//   params_ready in   acknowledgement from the configuration receiver
//   load_mode    out  high while the serial frame is being sent
//   serial_data  out  current frame bit, MSB first
//   busy         out  high whenever a transfer is in progress
//   done         out  one-cycle pulse at the end of every transfer
//   ok           out  result of the last transfer (1 = acknowledged)
module lif_param_loader #(
  parameter int unsigned FRAME_BITS = 40,
  parameter int unsigned CLK_DIV    = 1,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic                  params_ready,
  output logic                  load_mode,
  output logic                  serial_data,
  output logic                  busy,
  output logic                  done,
  output logic                  ok
);

  localparam int unsigned BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WAIT_RDY
  } state_t;

  state_t                state;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DIV_W-1:0]      div_cnt;
  logic [TMR_W-1:0]      wait_tmr;
  // Records that params_ready was seen low during this transfer, so a stale
  // acknowledgement left high from a previous load is never accepted.
  logic                  seen_low;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      div_cnt     <= '0;
      wait_tmr    <= '0;
      seen_low    <= 1'b0;
      load_mode   <= 1'b0;
      serial_data <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ok          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg   <= frame;
            ok          <= 1'b0;
            seen_low    <= 1'b0;
            bit_cnt     <= BIT_LAST;
            div_cnt     <= '0;
            state       <= SHIFT;
            busy        <= 1'b1;
            load_mode   <= 1'b1;
            // Registered output: present the MSB in the first SHIFT cycle.
            serial_data <= frame[FRAME_BITS-1];
          end
        end

        SHIFT: begin
          if (!params_ready) seen_low <= 1'b1;
          if (abort) begin
            state       <= IDLE;
            load_mode   <= 1'b0;
            serial_data <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            ok          <= 1'b0;
          end else if (div_cnt == DIV_LAST) begin
            div_cnt   <= '0;
            shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
            if (bit_cnt == '0) begin
              state       <= WAIT_RDY;
              wait_tmr    <= '0;
              load_mode   <= 1'b0;
              serial_data <= 1'b0;
            end else begin
              bit_cnt     <= bit_cnt - BIT_W'(1);
              // Next bit is the one just below the current MSB.
              serial_data <= shift_reg[FRAME_BITS-2];
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        WAIT_RDY: begin
          wait_tmr <= wait_tmr + TMR_W'(1);
          if (!params_ready) seen_low <= 1'b1;
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            ok    <= 1'b0;
          end else if (params_ready && seen_low) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            ok    <= 1'b1;
          end else if (wait_tmr == TMR_LAST) begin
            // Timer value TIMEOUT-1 marks the last permitted wait cycle.
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            ok    <= 1'b0;
          end
        end

        default: begin
          state       <= IDLE;
          load_mode   <= 1'b0;
          serial_data <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lif_param_loader.sv
// Directed self-checking bench for lif_param_loader.
// u_dut_a: FRAME_BITS=8, CLK_DIV=1, TIMEOUT=4.
// u_dut_b: FRAME_BITS=8, CLK_DIV=3, TIMEOUT=4.
module tb_lif_param_loader;

  logic       clk;
  logic       reset;
  logic       start_a;
  logic       start_b;
  logic       abort;
  logic [7:0] frame;
  logic       params_ready;

  logic load_mode_a, serial_data_a, busy_a, done_a, ok_a;
  logic load_mode_b, serial_data_b, busy_b, done_b, ok_b;

  int checks;
  int errors;

  lif_param_loader #(.FRAME_BITS(8), .CLK_DIV(1), .TIMEOUT(4)) u_dut_a (
    .clk          (clk),
    .reset        (reset),
    .start        (start_a),
    .abort        (abort),
    .frame        (frame),
    .params_ready (params_ready),
    .load_mode    (load_mode_a),
    .serial_data  (serial_data_a),
    .busy         (busy_a),
    .done         (done_a),
    .ok           (ok_a)
  );

  lif_param_loader #(.FRAME_BITS(8), .CLK_DIV(3), .TIMEOUT(4)) u_dut_b (
    .clk          (clk),
    .reset        (reset),
    .start        (start_b),
    .abort        (abort),
    .frame        (frame),
    .params_ready (params_ready),
    .load_mode    (load_mode_b),
    .serial_data  (serial_data_b),
    .busy         (busy_b),
    .done         (done_b),
    .ok           (ok_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Full transfer on u_dut_a, called at a negedge with the DUT idle (or in its
  // done cycle). ack_at = WAIT_RDY cycle in which params_ready is raised
  // (0 = never); the done pulse is expected one cycle later, else after cycle 4.
  task automatic xfer_a(input logic [7:0] f, input logic ready_high,
                        input int ack_at, input logic exp_ok);
    int exp_n;
    frame        = f;
    params_ready = ready_high;
    start_a      = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start_a = 1'b0;
      check("shift_load_mode", load_mode_a, 1'b1);
      check("shift_serial", serial_data_a, f[7-i]);
      check("shift_busy", busy_a, 1'b1);
    end
    exp_n = (ack_at > 0) ? ack_at + 1 : 5;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      check("wait_load_mode", load_mode_a, 1'b0);
      check("wait_serial", serial_data_a, 1'b0);
      check("wait_done", done_a, (n == exp_n));
      check("wait_busy", busy_a, (n < exp_n));
      if (n == ack_at) params_ready = 1'b1;
      if (n == exp_n) begin
        check("result_ok", ok_a, exp_ok);
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    start_a      = 1'b0;
    start_b      = 1'b0;
    abort        = 1'b0;
    frame        = 8'h00;
    params_ready = 1'b0;

    #2;
    check("rst_load_mode", load_mode_a, 1'b0);
    check("rst_serial", serial_data_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_ok", ok_a, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", busy_a, 1'b0);
    check("idle_done", done_a, 1'b0);

    // 0xA5 with acknowledgement raised two cycles after load_mode falls.
    xfer_a(8'hA5, 1'b0, 3, 1'b1);
    @(negedge clk);
    check("done_one_cycle", done_a, 1'b0);
    check("ok_holds", ok_a, 1'b1);

    // Stale acknowledgement held high throughout: must time out. Start is
    // asserted in the done cycle of this run for the next one.
    xfer_a(8'h96, 1'b1, 0, 1'b0);

    // Plain timeout with params_ready low, started in the previous done cycle.
    xfer_a(8'h3E, 1'b0, 0, 1'b0);
    @(negedge clk);
    check("timeout_done_cleared", done_a, 1'b0);

    // CLK_DIV=3, frame 0x81 on u_dut_b.
    frame        = 8'h81;
    params_ready = 1'b0;
    start_b      = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      start_b = 1'b0;
      check("div3_load_mode", load_mode_b, 1'b1);
      check("div3_serial", serial_data_b, (i < 3 || i >= 21));
    end
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      check("div3_wait_load_mode", load_mode_b, 1'b0);
      check("div3_done", done_b, (n == 5));
      check("div3_busy", busy_b, (n < 5));
    end
    check("div3_ok", ok_b, 1'b0);

    // Start ignored during SHIFT, then abort at bit 3.
    @(negedge clk);
    frame        = 8'hC3;
    params_ready = 1'b0;
    start_a      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start_a = (i == 1);
      if (i == 1) frame = 8'hFF;
      check("abort_shift_serial", serial_data_a, ((8'hC3 >> (7 - i)) & 8'h01));
      check("abort_shift_load", load_mode_a, 1'b1);
      if (i == 3) abort = 1'b1;
    end
    @(negedge clk);
    abort = 1'b0;
    check("abort_load_mode", load_mode_a, 1'b0);
    check("abort_serial", serial_data_a, 1'b0);
    check("abort_done", done_a, 1'b1);
    check("abort_ok", ok_a, 1'b0);
    check("abort_busy", busy_a, 1'b0);
    @(negedge clk);
    check("abort_done_cleared", done_a, 1'b0);
    check("abort_stays_idle", busy_a, 1'b0);
    xfer_a(8'h5A, 1'b0, 2, 1'b1);

    // Reset mid-SHIFT: outputs clear before the next clock edge.
    @(negedge clk);
    frame        = 8'h3C;
    params_ready = 1'b0;
    start_a      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    check("pre_reset_serial", serial_data_a, 1'b1);
    reset = 1'b1;
    #1;
    check("async_rst_load_mode", load_mode_a, 1'b0);
    check("async_rst_busy", busy_a, 1'b0);
    check("async_rst_serial", serial_data_a, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_done", done_a, 1'b0);
    check("post_rst_busy", busy_a, 1'b0);
    @(negedge clk);
    check("post_rst_done2", done_a, 1'b0);
    xfer_a(8'h3C, 1'b0, 2, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
